alignment_ctrl: RTL and testbench

//  Sequencer for one Alignment block (3 crate streams). Per event: pulses the aligner reset,

---
 rtl/alignment_ctrl_if.sv | 31 +++
 rtl/alignment_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_alignment_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alignment_ctrl_if.sv
// Signal bundle between run control, the aligner and alignment_ctrl.
// master = run control / aligner side, slave = alignment_ctrl.
interface alignment_ctrl_if;
    logic        start;
    logic        cfg_mask;
    logic [4:0]  cfg_input_id;
    logic [15:0] al_out0;
    logic [5:0]  al_debug;
    logic        al_reset;
    logic        al_mask;
    logic [4:0]  al_input_id;
    logic        busy;
    logic        done;
    logic        err;
    logic        abort;
    logic [2:0]  err_code;
    logic [15:0] evt_cnt;
    logic [7:0]  err_cnt;

    modport master (
        output start, cfg_mask, cfg_input_id, al_out0, al_debug,
        input  al_reset, al_mask, al_input_id, busy, done, err, abort,
               err_code, evt_cnt, err_cnt
    );

    modport slave (
        input  start, cfg_mask, cfg_input_id, al_out0, al_debug,
        output al_reset, al_mask, al_input_id, busy, done, err, abort,
               err_code, evt_cnt, err_cnt
    );
endinterface

// File: rtl/alignment_ctrl.sv
// Per-event sequencer for one aligner: arm, wait, count packet, check debug flags, retry.
// Optional macro ALIGN_CTRL_AUTO_EN: free-running re-alignment without the start input.
module alignment_ctrl #(
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 64,
    parameter int PKT_LEN    = 19,
    parameter int MAX_RETRY  = 3
) (
    input  logic            clk,
    input  logic            reset,
    alignment_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARM    = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_FAIL   = 3'd5;

    localparam logic [2:0] E_NONE    = 3'd0;
    localparam logic [2:0] E_TIMEOUT = 3'd1;
    localparam logic [2:0] E_LENGTH  = 3'd2;
    localparam logic [2:0] E_HEADER  = 3'd3;
    localparam logic [2:0] E_CRATE   = 3'd4;

    localparam logic [15:0] NO_DATA = 16'd999;

    localparam int RC_W  = $clog2(RST_CYCLES + 1);
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam int CNT_W = $clog2(PKT_LEN + 1);
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PKT_LEN);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    logic [2:0]       state_q, state_d;
    logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [RTY_W-1:0] retry_q, retry_d;

    logic        al_reset_q, al_reset_d;
    logic        al_mask_q, al_mask_d;
    logic [4:0]  al_input_id_q, al_input_id_d;
    logic        busy_q;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        abort_q, abort_d;
    logic [2:0]  err_code_q, err_code_d;
    logic [15:0] evt_cnt_q, evt_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic valid_s;
    logic go_s;

    assign valid_s = (bus.al_out0 != NO_DATA);

`ifdef ALIGN_CTRL_AUTO_EN
    // Free-running: IDLE is only ever a one-cycle gap between events.
    assign go_s = 1'b1;
`else
    assign go_s = bus.start;
`endif

    // Next-state and next-output logic for the event sequencer.
    always_comb begin
        state_d       = state_q;
        rst_cnt_d     = rst_cnt_q;
        timer_d       = timer_q;
        count_d       = count_q;
        retry_d       = retry_q;
        al_reset_d    = 1'b0;
        al_mask_d     = al_mask_q;
        al_input_id_d = al_input_id_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        abort_d       = 1'b0;
        err_code_d    = err_code_q;
        evt_cnt_d     = evt_cnt_q;
        err_cnt_d     = err_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (go_s) begin
                    state_d       = S_ARM;
                    al_mask_d     = bus.cfg_mask;
                    al_input_id_d = bus.cfg_input_id;
                    retry_d       = '0;
                    rst_cnt_d     = '0;
                    al_reset_d    = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARM: begin
                if (rst_cnt_q == RC_LAST) begin
                    state_d = S_WAIT;
                    timer_d = '0;
                end else begin
                    rst_cnt_d  = rst_cnt_q + RC_W'(1);
                    al_reset_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (valid_s) begin
                    state_d = S_STREAM;
                    count_d = CNT_W'(1);
                end else if (timer_q == TMR_LAST) begin
                    state_d    = S_FAIL;
                    err_code_d = E_TIMEOUT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_STREAM: begin
                // An over-long packet fails on the extra word, not at its end.
                if (valid_s) begin
                    if (count_q == CNT_FULL) begin
                        state_d    = S_FAIL;
                        err_code_d = E_LENGTH;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end else if (count_q == CNT_FULL) begin
                    state_d = S_CHECK;
                end else begin
                    state_d    = S_FAIL;
                    err_code_d = E_LENGTH;
                end
            end
            S_CHECK: begin
                if (bus.al_debug[2:0] != 3'b000) begin
                    state_d    = S_FAIL;
                    err_code_d = E_HEADER;
                end else if (bus.al_debug[5:3] != 3'b000) begin
                    state_d    = S_FAIL;
                    err_code_d = E_CRATE;
                end else begin
                    state_d    = S_IDLE;
                    done_d     = 1'b1;
                    evt_cnt_d  = evt_cnt_q + 16'd1;
                    err_code_d = E_NONE;
                end
            end
            S_FAIL: begin
                err_d = 1'b1;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end else begin
                    err_cnt_d = err_cnt_q;
                end
                if (retry_q < RTY_MAX) begin
                    state_d    = S_ARM;
                    retry_d    = retry_q + RTY_W'(1);
                    rst_cnt_d  = '0;
                    al_reset_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    abort_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rst_cnt_q     <= '0;
            timer_q       <= '0;
            count_q       <= '0;
            retry_q       <= '0;
            al_reset_q    <= 1'b0;
            al_mask_q     <= 1'b0;
            al_input_id_q <= 5'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            abort_q       <= 1'b0;
            err_code_q    <= 3'd0;
            evt_cnt_q     <= 16'd0;
            err_cnt_q     <= 8'd0;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            timer_q       <= timer_d;
            count_q       <= count_d;
            retry_q       <= retry_d;
            al_reset_q    <= al_reset_d;
            al_mask_q     <= al_mask_d;
            al_input_id_q <= al_input_id_d;
            busy_q        <= (state_d != S_IDLE);
            done_q        <= done_d;
            err_q         <= err_d;
            abort_q       <= abort_d;
            err_code_q    <= err_code_d;
            evt_cnt_q     <= evt_cnt_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign bus.al_reset    = al_reset_q;
    assign bus.al_mask     = al_mask_q;
    assign bus.al_input_id = al_input_id_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.abort       = abort_q;
    assign bus.err_code    = err_code_q;
    assign bus.evt_cnt     = evt_cnt_q;
    assign bus.err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_alignment_ctrl.sv
// Directed bench for alignment_ctrl; the bench plays run control and the aligner.
`timescale 1ns/1ps
module tb_alignment_ctrl;
    logic clk = 1'b0;
    logic reset;
    int total = 0;
    int bad   = 0;
    int n_done = 0, n_err = 0, n_abort = 0, n_rst_cyc = 0, n_rst_pulse = 0;
    logic rst_prev = 1'b0;

    alignment_ctrl_if bus();
    alignment_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Pulse/cycle monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.done)  n_done++;
            if (bus.err)   n_err++;
            if (bus.abort) n_abort++;
            if (bus.al_reset) n_rst_cyc++;
            if (bus.al_reset && !rst_prev) n_rst_pulse++;
            rst_prev = bus.al_reset;
        end else begin
            rst_prev = 1'b0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic m, input logic [4:0] id);
        bus.cfg_mask = m;
        bus.cfg_input_id = id;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    // Aligner model: wait out the aligner reset, idle, then stream nwords, then 999.
    task automatic feed(input int idle, input int nwords, input int pulse_at);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.al_reset === 1'b1) seen = 1'b1;
            else if (seen) break;
            cyc();
        end
        total++;
        if (!(seen && bus.al_reset === 1'b0)) begin
            $display("FAIL feed_sync: al_reset=%b seen=%b, required a completed reset pulse", bus.al_reset, seen);
            bad++;
        end
        for (int i = 0; i < idle; i++) cyc();
        for (int w = 1; w <= nwords; w++) begin
            bus.al_out0 = 16'(w * 3);
            bus.start = (w == pulse_at);
            cyc();
        end
        bus.start = 1'b0;
        bus.al_out0 = 16'd999;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.cfg_mask = 1'b0; bus.cfg_input_id = 5'd0;
        bus.al_out0 = 16'd999; bus.al_debug = 6'd0;
        cyc(); cyc(); cyc();
        total++;
        if ({bus.al_reset, bus.al_mask, bus.al_input_id, bus.busy, bus.done, bus.err, bus.abort,
             bus.err_code, bus.evt_cnt, bus.err_cnt} !== 40'd0) begin
            $display("FAIL reset_outputs: got busy=%b evt=%0d err_cnt=%0d code=%0d, required all 0",
                     bus.busy, bus.evt_cnt, bus.err_cnt, bus.err_code);
            bad++;
        end
        reset = 1'b0;
    endtask

    task automatic test_clean();
        int d0, r0;
        d0 = n_done; r0 = n_rst_cyc;
        cyc();
        total++;
        if (bus.busy !== 1'b0) begin $display("FAIL idle_busy: got %b required 0", bus.busy); bad++; end
        kick(1'b0, 5'd5);
        bus.cfg_input_id = 5'd7;
        total++;
        if ({bus.al_reset, bus.busy, bus.al_input_id} !== {1'b1, 1'b1, 5'd5}) begin
            $display("FAIL start_latency: al_reset=%b busy=%b id=%0d required 1 1 5", bus.al_reset, bus.busy, bus.al_input_id);
            bad++;
        end
        feed(10, 19, 0);
        cyc();
        total++;
        if (bus.done !== 1'b0) begin $display("FAIL done_early: got %b required 0", bus.done); bad++; end
        cyc();
        total++;
        if ({bus.done, bus.busy} !== 2'b10) begin $display("FAIL done_latency: done=%b busy=%b required 1 0", bus.done, bus.busy); bad++; end
        total++;
        if ({bus.evt_cnt, bus.err_cnt, bus.err_code, bus.al_input_id, bus.al_mask} !== {16'd1, 8'd0, 3'd0, 5'd5, 1'b0}) begin
            $display("FAIL clean_stats: evt=%0d errc=%0d code=%0d id=%0d mask=%b required 1 0 0 5 0",
                     bus.evt_cnt, bus.err_cnt, bus.err_code, bus.al_input_id, bus.al_mask);
            bad++;
        end
        cyc();
        total++;
        if ((n_rst_cyc - r0) != 2 || (n_done - d0) != 1) begin
            $display("FAIL clean_pulses: rst_cycles=%0d dones=%0d required 2 1", n_rst_cyc - r0, n_done - d0);
            bad++;
        end
    endtask

    task automatic test_timeout();
        int e0, a0, p0, n;
        e0 = n_err; a0 = n_abort; p0 = n_rst_pulse;
        kick(1'b1, 5'd3);
        n = 0;
        while (bus.abort !== 1'b1 && n < 400) begin cyc(); n++; end
        total++;
        if (n != 268) begin $display("FAIL timeout_cycles: got %0d required 268", n); bad++; end
        total++;
        if ({bus.err_code, bus.err_cnt, bus.busy, bus.al_mask, bus.al_input_id} !== {3'd1, 8'd4, 1'b0, 1'b1, 5'd3}) begin
            $display("FAIL timeout_state: code=%0d errc=%0d busy=%b mask=%b id=%0d required 1 4 0 1 3",
                     bus.err_code, bus.err_cnt, bus.busy, bus.al_mask, bus.al_input_id);
            bad++;
        end
        cyc();
        total++;
        if ((n_err - e0) != 4 || (n_abort - a0) != 1 || (n_rst_pulse - p0) != 4) begin
            $display("FAIL timeout_pulses: errs=%0d aborts=%0d rst_pulses=%0d required 4 1 4",
                     n_err - e0, n_abort - a0, n_rst_pulse - p0);
            bad++;
        end
    endtask

    task automatic test_length();
        kick(1'b0, 5'd2);
        feed(3, 15, 0);
        cyc();
        total++;
        if ({bus.err_code, bus.err} !== {3'd2, 1'b0}) begin $display("FAIL short_code: code=%0d err=%b required 2 0", bus.err_code, bus.err); bad++; end
        cyc();
        total++;
        if ({bus.err, bus.al_reset, bus.busy} !== 3'b111) begin
            $display("FAIL short_rearm: err=%b al_reset=%b busy=%b required 1 1 1", bus.err, bus.al_reset, bus.busy);
            bad++;
        end
        feed(5, 19, 0);
        cyc(); cyc();
        total++;
        if ({bus.done, bus.err_code, bus.evt_cnt} !== {1'b1, 3'd0, 16'd2}) begin
            $display("FAIL retry_clean: done=%b code=%0d evt=%0d required 1 0 2", bus.done, bus.err_code, bus.evt_cnt);
            bad++;
        end
        cyc();
        kick(1'b0, 5'd2);
        feed(2, 19, 0);
        total++;
        if (bus.err_code !== 3'd0) begin $display("FAIL long_pre: code=%0d required 0", bus.err_code); bad++; end
        bus.al_out0 = 16'd60;
        cyc();
        total++;
        if (bus.err_code !== 3'd2) begin $display("FAIL long_code: code=%0d required 2", bus.err_code); bad++; end
        bus.al_out0 = 16'd999;
        cyc();
        total++;
        if (bus.err !== 1'b1) begin $display("FAIL long_err: err=%b required 1", bus.err); bad++; end
        feed(1, 19, 0);
        cyc(); cyc();
        total++;
        if ({bus.done, bus.evt_cnt, bus.err_cnt} !== {1'b1, 16'd3, 8'd6}) begin
            $display("FAIL long_recover: done=%b evt=%0d errc=%0d required 1 3 6", bus.done, bus.evt_cnt, bus.err_cnt);
            bad++;
        end
        cyc();
    endtask

    task automatic test_debug();
        bus.al_debug = 6'b001001;
        kick(1'b0, 5'd1);
        feed(0, 19, 0);
        cyc(); cyc();
        total++;
        if ({bus.err_code, bus.done} !== {3'd3, 1'b0}) begin $display("FAIL header_code: code=%0d done=%b required 3 0", bus.err_code, bus.done); bad++; end
        bus.al_debug = 6'b010000;
        cyc();
        feed(0, 19, 0);
        cyc(); cyc();
        total++;
        if (bus.err_code !== 3'd4) begin $display("FAIL crate_code: code=%0d required 4", bus.err_code); bad++; end
        bus.al_debug = 6'd0;
        cyc();
        feed(0, 19, 0);
        cyc(); cyc();
        total++;
        if ({bus.done, bus.err_code, bus.evt_cnt, bus.err_cnt} !== {1'b1, 3'd0, 16'd4, 8'd8}) begin
            $display("FAIL debug_recover: done=%b code=%0d evt=%0d errc=%0d required 1 0 4 8",
                     bus.done, bus.err_code, bus.evt_cnt, bus.err_cnt);
            bad++;
        end
        cyc();
    endtask

    task automatic test_midreset();
        int d0, e0;
        kick(1'b1, 5'd6);
        feed(3, 8, 0);
        total++;
        if (bus.busy !== 1'b1) begin $display("FAIL mid_busy: got %b required 1", bus.busy); bad++; end
        d0 = n_done; e0 = n_err;
        reset = 1'b1;
        #1;
        total++;
        if ({bus.al_reset, bus.al_mask, bus.al_input_id, bus.busy, bus.done, bus.err, bus.abort,
             bus.err_code, bus.evt_cnt, bus.err_cnt} !== 40'd0) begin
            $display("FAIL async_reset: busy=%b evt=%0d errc=%0d mask=%b required all 0",
                     bus.busy, bus.evt_cnt, bus.err_cnt, bus.al_mask);
            bad++;
        end
        cyc(); cyc();
        reset = 1'b0;
        cyc(); cyc();
        total++;
        if ((n_done - d0) != 0 || (n_err - e0) != 0 || bus.busy !== 1'b0) begin
            $display("FAIL reset_quiet: dones=%0d errs=%0d busy=%b required 0 0 0", n_done - d0, n_err - e0, bus.busy);
            bad++;
        end
        kick(1'b0, 5'd9);
        total++;
        if ({bus.al_reset, bus.al_input_id} !== {1'b1, 5'd9}) begin
            $display("FAIL restart: al_reset=%b id=%0d required 1 9", bus.al_reset, bus.al_input_id);
            bad++;
        end
        feed(2, 19, 0);
        cyc(); cyc();
        total++;
        if ({bus.done, bus.evt_cnt} !== {1'b1, 16'd1}) begin $display("FAIL restart_done: done=%b evt=%0d required 1 1", bus.done, bus.evt_cnt); bad++; end
        cyc();
    endtask

    task automatic test_busy_start();
        kick(1'b0, 5'd4);
        feed(1, 19, 8);
        cyc(); cyc();
        total++;
        if ({bus.done, bus.evt_cnt} !== {1'b1, 16'd2}) begin $display("FAIL busy_start_done: done=%b evt=%0d required 1 2", bus.done, bus.evt_cnt); bad++; end
        cyc(); cyc(); cyc();
        total++;
        if ({bus.busy, bus.al_reset} !== 2'b00) begin
            $display("FAIL start_not_queued: busy=%b al_reset=%b required 0 0", bus.busy, bus.al_reset);
            bad++;
        end
    endtask

    task automatic test_auto();
        for (int k = 0; k < 3; k++) begin
            feed(2, 19, 0);
            cyc(); cyc();
            total++;
            if ({bus.done, bus.busy} !== 2'b10) begin $display("FAIL auto_done: done=%b busy=%b required 1 0", bus.done, bus.busy); bad++; end
            cyc();
            total++;
            if ({bus.busy, bus.al_reset} !== 2'b11) begin
                $display("FAIL auto_rearm: busy=%b al_reset=%b required 1 1", bus.busy, bus.al_reset);
                bad++;
            end
        end
        total++;
        if (bus.evt_cnt !== 16'd3) begin $display("FAIL auto_evt: got %0d required 3", bus.evt_cnt); bad++; end
    endtask

    initial begin
        test_reset();
`ifdef ALIGN_CTRL_AUTO_EN
        test_auto();
`else
        test_clean();
        test_timeout();
        test_length();
        test_debug();
        test_midreset();
        test_busy_start();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
